// File: rtl/watch_pkg.sv
// Shared limits, scan-position encoding and hour-format helper for the watch time generator.
package watch_pkg;

    localparam logic [7:0] HOUR_MAX  = 8'd23;
    localparam logic [7:0] MIN_MAX   = 8'd59;
    localparam logic [7:0] SEC_MAX   = 8'd59;
    localparam logic [7:0] HOUR_NOON = 8'd12;

    // Bit 0 of the one-hot select is the rightmost display position.
    typedef enum logic [2:0] {
        POS_SEC_U = 3'd0,
        POS_SEC_T = 3'd1,
        POS_MIN_U = 3'd2,
        POS_MIN_T = 3'd3,
        POS_HR_U  = 3'd4,
        POS_HR_T  = 3'd5
    } scan_pos_e;

    function automatic logic [7:0] to_12h(input logic [7:0] h);
        if (h == 8'd0) begin
            return HOUR_NOON;
        end else if (h > HOUR_NOON) begin
            return h - HOUR_NOON;
        end else begin
            return h;
        end
    endfunction

endpackage

// File: rtl/bcd_split.sv
// Combinational tens/units split of a 0..59 binary value using a constant comparator ladder.
module bcd_split (
    input  logic [7:0] value_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    always_comb begin
        tens_o  = 4'd0;
        units_o = value_i[3:0];
        if (value_i >= 8'd50) begin
            tens_o  = 4'd5;
            units_o = 4'(value_i - 8'd50);
        end else if (value_i >= 8'd40) begin
            tens_o  = 4'd4;
            units_o = 4'(value_i - 8'd40);
        end else if (value_i >= 8'd30) begin
            tens_o  = 4'd3;
            units_o = 4'(value_i - 8'd30);
        end else if (value_i >= 8'd20) begin
            tens_o  = 4'd2;
            units_o = 4'(value_i - 8'd20);
        end else if (value_i >= 8'd10) begin
            tens_o  = 4'd1;
            units_o = 4'(value_i - 8'd10);
        end
    end

endmodule

// File: rtl/clock_time_gen.sv
// Time-of-day generator with run/pause, validated time load, 12/24-hour display
// and a free-running digit scanner producing one-hot select plus BCD digit.
module clock_time_gen
    import watch_pkg::*;
#(
    parameter logic [15:0] CNT_1MS_MAX = 16'd49_999,
    parameter int unsigned MS_PER_SEC  = 1000,
    parameter int unsigned SCAN_DIGITS = 6,
    parameter int unsigned INIT_H      = 15,
    parameter int unsigned INIT_M      = 57,
    parameter int unsigned INIT_S      = 34
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   mode_12h,
    input  logic                   set_en,
    input  logic [7:0]             set_h,
    input  logic [7:0]             set_m,
    input  logic [7:0]             set_s,
    output logic [7:0]             hours,
    output logic [7:0]             minutes,
    output logic [7:0]             seconds,
    output logic                   pm,
    output logic                   tick_1s,
    output logic                   set_err,
    output logic [SCAN_DIGITS-1:0] sel,
    output logic [3:0]             digit_bcd
);

    localparam int unsigned SUB_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(MS_PER_SEC - 1);
    localparam int unsigned IDX_W = $clog2(SCAN_DIGITS);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SCAN_DIGITS - 1);

    logic [15:0]            cnt_ms_q, cnt_ms_d;
    logic [15:0]            scan_cnt_q, scan_cnt_d;
    logic [SUB_W-1:0]       cnt_sub_q, cnt_sub_d;
    logic [7:0]             hours_q, hours_d;
    logic [7:0]             minutes_q, minutes_d;
    logic [7:0]             seconds_q, seconds_d;
    logic                   tick_q, tick_d;
    logic                   err_q, err_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SCAN_DIGITS-1:0] sel_q, sel_d;
    logic [3:0]             digit_q, digit_d;

    logic      ms_tick, run_tick, sec_tick, scan_tick;
    logic      set_ok, load;
    logic [7:0] disp_hours, bcd_val;
    logic [3:0] bcd_tens, bcd_units;
    logic      use_tens;
    scan_pos_e pos;

    assign ms_tick   = (cnt_ms_q == CNT_1MS_MAX);
    assign run_tick  = run & ms_tick;
    assign sec_tick  = run_tick & (cnt_sub_q == SUB_MAX);
    assign scan_tick = (scan_cnt_q == CNT_1MS_MAX);
    assign set_ok    = (set_h <= HOUR_MAX) & (set_m <= MIN_MAX) & (set_s <= SEC_MAX);
    assign load      = set_en & set_ok;

    always_comb begin
        cnt_ms_d  = cnt_ms_q;
        cnt_sub_d = cnt_sub_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        tick_d    = 1'b0;
        err_d     = set_en & ~set_ok;

        if (run) begin
            cnt_ms_d = ms_tick ? '0 : cnt_ms_q + 16'd1;
        end
        if (run_tick) begin
            cnt_sub_d = sec_tick ? '0 : cnt_sub_q + SUB_W'(1);
        end

        // A valid load restarts the second and pre-empts a coincident increment.
        if (load) begin
            hours_d   = set_h;
            minutes_d = set_m;
            seconds_d = set_s;
            cnt_ms_d  = '0;
            cnt_sub_d = '0;
        end else if (sec_tick) begin
            tick_d = 1'b1;
            if (seconds_q == SEC_MAX) begin
                seconds_d = '0;
                if (minutes_q == MIN_MAX) begin
                    minutes_d = '0;
                    hours_d   = (hours_q == HOUR_MAX) ? '0 : hours_q + 8'd1;
                end else begin
                    minutes_d = minutes_q + 8'd1;
                end
            end else begin
                seconds_d = seconds_q + 8'd1;
            end
        end
    end

    assign disp_hours = mode_12h ? to_12h(hours_q) : hours_q;

    // With four positions the scan starts at minute units, so shift the index by two.
    always_comb begin
        pos      = scan_pos_e'(3'(idx_q) + ((SCAN_DIGITS == 4) ? 3'd2 : 3'd0));
        bcd_val  = seconds_q;
        use_tens = 1'b0;
        case (pos)
            POS_SEC_U: begin bcd_val = seconds_q;  use_tens = 1'b0; end
            POS_SEC_T: begin bcd_val = seconds_q;  use_tens = 1'b1; end
            POS_MIN_U: begin bcd_val = minutes_q;  use_tens = 1'b0; end
            POS_MIN_T: begin bcd_val = minutes_q;  use_tens = 1'b1; end
            POS_HR_U:  begin bcd_val = disp_hours; use_tens = 1'b0; end
            POS_HR_T:  begin bcd_val = disp_hours; use_tens = 1'b1; end
            default:   begin bcd_val = seconds_q;  use_tens = 1'b0; end
        endcase
    end

    bcd_split u_bcd_split (
        .value_i (bcd_val),
        .tens_o  (bcd_tens),
        .units_o (bcd_units)
    );

    // Scanning has its own prescaler copy so pausing time never freezes the display.
    always_comb begin
        scan_cnt_d = scan_tick ? '0 : scan_cnt_q + 16'd1;
        idx_d      = idx_q;
        sel_d      = sel_q;
        digit_d    = digit_q;
        if (scan_tick) begin
            idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
            sel_d   = SCAN_DIGITS'(1) << idx_q;
            digit_d = use_tens ? bcd_tens : bcd_units;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ms_q   <= '0;
            scan_cnt_q <= '0;
            cnt_sub_q  <= '0;
            hours_q    <= 8'(INIT_H);
            minutes_q  <= 8'(INIT_M);
            seconds_q  <= 8'(INIT_S);
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            sel_q      <= '0;
            digit_q    <= '0;
        end else begin
            cnt_ms_q   <= cnt_ms_d;
            scan_cnt_q <= scan_cnt_d;
            cnt_sub_q  <= cnt_sub_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            digit_q    <= digit_d;
        end
    end

    assign hours     = hours_q;
    assign minutes   = minutes_q;
    assign seconds   = seconds_q;
    assign pm        = (hours_q >= HOUR_NOON);
    assign tick_1s   = tick_q;
    assign set_err   = err_q;
    assign sel       = sel_q;
    assign digit_bcd = digit_q;

endmodule
